// File: rtl/display_scan.sv
// rtl/display_scan.sv - multiplexed seven-segment scanner with frame snapshot and error message (optional blink: DISPLAY_BLINK_EN)
module display_scan #(
    parameter int DIGITS       = 8,
    parameter int DIVIDER      = 1024,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   number,
    input  logic [DIGITS-1:0]     dot_mask,
    input  logic                  overflow,
    input  logic [3:0]            error,
    input  logic                  blank_leading,
    output logic [6:0]            seven_segments,
    output logic                  dot,
    output logic [DIGITS-1:0]     anodes
);

    localparam int PW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIVIDER - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [IW-1:0] IDX_R_HI  = IW'(DIGITS - 2);
    localparam logic [IW-1:0] IDX_R_LO  = IW'(DIGITS - 3);

    localparam logic [6:0] SEG_DARK = 7'b1111111;
    localparam logic [6:0] SEG_E    = 7'b0000110;
    localparam logic [6:0] SEG_R    = 7'b0101111;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0:    hex_glyph = 7'b1000000;
            4'h1:    hex_glyph = 7'b1111001;
            4'h2:    hex_glyph = 7'b0100100;
            4'h3:    hex_glyph = 7'b0110000;
            4'h4:    hex_glyph = 7'b0011001;
            4'h5:    hex_glyph = 7'b0010010;
            4'h6:    hex_glyph = 7'b0000010;
            4'h7:    hex_glyph = 7'b1111000;
            4'h8:    hex_glyph = 7'b0000000;
            4'h9:    hex_glyph = 7'b0011000;
            4'hA:    hex_glyph = 7'b0001000;
            4'hB:    hex_glyph = 7'b0000011;
            4'hC:    hex_glyph = 7'b1000110;
            4'hD:    hex_glyph = 7'b0100001;
            4'hE:    hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;
    logic                tick;
    logic                frame_end;

    logic [4*DIGITS-1:0] number_sh;
    logic [DIGITS-1:0]   dot_mask_sh;
    logic                overflow_sh;
    logic [3:0]          error_sh;
    logic                dark_now;

    logic [DIGITS-1:0]   sel;
    logic [DIGITS-1:0]   upper_zero;
    logic [3:0]          cur_nib;
    logic                cur_dot;
    logic                cur_upper_zero;

    // With DIVIDER=1 pcnt is stuck at 0 and tick is permanently high
    assign tick      = (pcnt == PCNT_LAST);
    assign frame_end = tick && (idx == IDX_LAST);

    // Prescaler and digit scan index
    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Shadow registers refreshed only at the frame boundary so a frame is never mixed
    always_ff @(posedge clock) begin
        if (reset) begin
            number_sh   <= '0;
            dot_mask_sh <= '0;
            overflow_sh <= 1'b0;
            error_sh    <= 4'h0;
        end else if (frame_end) begin
            number_sh   <= number;
            dot_mask_sh <= dot_mask;
            overflow_sh <= overflow;
            error_sh    <= error;
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_dark;

    // Frame counter for the error blink; held clear outside error mode so each error starts lit
    always_ff @(posedge clock) begin
        if (reset || (error_sh == 4'h0)) begin
            blink_cnt  <= '0;
            blink_dark <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt  <= '0;
                blink_dark <= ~blink_dark;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign dark_now = blink_dark;
`else
    assign dark_now = 1'b0;
`endif

    // Per-digit "this nibble and everything to its left is zero" flags
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        upper_zero = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run & (number_sh[4*k +: 4] == 4'h0);
            upper_zero[k] = zero_run;
        end
    end

    // Select the current digit's nibble, dot and blanking flag
    always_comb begin
        sel            = '0;
        cur_nib        = 4'h0;
        cur_dot        = 1'b0;
        cur_upper_zero = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                sel[k]         = 1'b1;
                cur_nib        = number_sh[4*k +: 4];
                cur_dot        = dot_mask_sh[k];
                cur_upper_zero = upper_zero[k];
            end
        end
    end

    // Registered active-low pin drive, one cycle behind idx
    always_ff @(posedge clock) begin
        if (reset) begin
            seven_segments <= SEG_ZERO;
            dot            <= 1'b1;
            anodes         <= '1;
        end else if (error_sh != 4'h0) begin
            dot <= 1'b1;
            if (dark_now) begin
                anodes         <= '1;
                seven_segments <= SEG_DARK;
            end else begin
                anodes <= ~sel;
                if (idx == IDX_LAST) begin
                    seven_segments <= SEG_E;
                end else if ((idx == IDX_R_HI) || (idx == IDX_R_LO)) begin
                    seven_segments <= SEG_R;
                end else if (idx == '0) begin
                    seven_segments <= hex_glyph(error_sh);
                end else begin
                    seven_segments <= SEG_DARK;
                end
            end
        end else begin
            anodes <= ~sel;
            dot    <= ~(cur_dot | ((idx == '0) & overflow_sh));
            if (blank_leading && (idx != '0) && cur_upper_zero) begin
                seven_segments <= SEG_DARK;
            end else begin
                seven_segments <= hex_glyph(cur_nib);
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - scoreboard bench for display_scan (DIGITS=4, DIVIDER=4, BLINK_FRAMES=2)
module tb_display_scan;

`ifdef DISPLAY_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam logic [27:0] ZERO4 = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    localparam logic [27:0] ERR5  = {7'b0000110, 7'b0101111, 7'b0101111, 7'b0010010};

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] number;
    logic [3:0]  dot_mask;
    logic        overflow;
    logic [3:0]  error;
    logic        blank_leading;
    logic [6:0]  seven_segments;
    logic        dot;
    logic [3:0]  anodes;

    typedef struct {
        int         tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dt;
        bit         an_only;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    display_scan #(
        .DIGITS       (4),
        .DIVIDER      (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .number         (number),
        .dot_mask       (dot_mask),
        .overflow       (overflow),
        .error          (error),
        .blank_leading  (blank_leading),
        .seven_segments (seven_segments),
        .dot            (dot),
        .anodes         (anodes)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pop every expectation tagged for this cycle and compare
    always @(negedge clock) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].tag <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.tag != cyc) begin
                errors++;
                $display("FAIL %s stale expectation tag=%0d seen at cycle %0d", e.name, e.tag, cyc);
            end else if (anodes !== e.an ||
                         (!e.an_only && (seven_segments !== e.seg || dot !== e.dt))) begin
                errors++;
                $display("FAIL %s cycle=%0d got an=%b seg=%b dot=%b want an=%b seg=%b dot=%b%s",
                         e.name, cyc, anodes, seven_segments, dot, e.an, e.seg, e.dt,
                         e.an_only ? " (anodes only)" : "");
            end
        end
    end

    task automatic push_one(input int tag, input logic [3:0] an, input logic [6:0] seg,
                            input logic dt, input string name);
        exp_t e;
        e.tag = tag; e.an = an; e.seg = seg; e.dt = dt; e.an_only = 1'b0; e.name = name;
        q.push_back(e);
    endtask

    // segs packed {digit3, digit2, digit1, digit0}; dots bit d is the expected dot pin for digit d
    task automatic push_frame(input int start, input int lim, input bit dark,
                              input logic [27:0] segs, input logic [3:0] dots, input string name);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 4; k++) begin
                if (4 * d + k < lim) begin
                    e.tag     = start + 4 * d + k;
                    e.an      = dark ? 4'b1111 : ~(4'b0001 << d);
                    e.seg     = segs[7 * d +: 7];
                    e.dt      = dots[d];
                    e.an_only = dark;
                    e.name    = name;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_edge(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; number = 16'h0; dot_mask = 4'h0; overflow = 1'b0;
        error = 4'h0; blank_leading = 1'b0;
        for (int t = 1; t <= 3; t++) push_one(t, 4'b1111, 7'b1000000, 1'b1, "reset");

        wait_edge(3);
        reset = 1'b0;
        push_frame(4, 16, 1'b0, ZERO4, 4'hF, "frame0");

        wait_edge(4);
        number = 16'h12AB;
        push_frame(20, 16, 1'b0, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0000011}, 4'hF, "hex_12ab");

        wait_edge(28);
        number = 16'h0000;
        push_frame(36, 16, 1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'hF, "blank_zero");

        wait_edge(36);
        number = 16'h0042;
        blank_leading = 1'b1;
        push_frame(52, 16, 1'b0, {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100}, 4'hF, "blank_0042");

        wait_edge(52);
        dot_mask = 4'b0100;
        overflow = 1'b1;
        push_frame(68, 16, 1'b0, {7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100}, 4'b1010, "dots");

        wait_edge(68);
        blank_leading = 1'b0;
        error = 4'h5;
        push_frame(84,  16, 1'b0,  ERR5, 4'hF, "err_f1");
        push_frame(100, 16, 1'b0,  ERR5, 4'hF, "err_f2");
        push_frame(116, 16, BLINK, ERR5, 4'hF, "err_f3");
        push_frame(132, 16, BLINK, ERR5, 4'hF, "err_f4");
        push_frame(148, 16, 1'b0,  ERR5, 4'hF, "err_f5");
        push_frame(164, 9,  1'b0,  ERR5, 4'hF, "err_f6");

        wait_edge(172);
        reset = 1'b1;
        push_one(173, 4'b1111, 7'b1000000, 1'b1, "mid_reset");

        wait_edge(173);
        reset = 1'b0;
        push_frame(174, 16, 1'b0, ZERO4, 4'hF, "after_reset");
        push_frame(190, 16, 1'b0, ERR5,  4'hF, "recapture");

        wait_edge(206);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain %0d expectations left, want 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
